// File: rtl/reg_wb_arbiter_if.sv
// Producer-side bus of the write-back arbiter: ALU result, load return and load issue.
interface reg_wb_arbiter_if #(
  parameter int DATA_LENGTH     = 32,
  parameter int REG_ADDR_LENGTH = 5
);
  logic                       alu_valid;
  logic [REG_ADDR_LENGTH-1:0] alu_rd;
  logic [DATA_LENGTH-1:0]     alu_data;
  logic                       alu_stall;
  logic                       mem_valid;
  logic [REG_ADDR_LENGTH-1:0] mem_rd;
  logic [DATA_LENGTH-1:0]     mem_data;
  logic                       mem_ready;
  logic                       issue_valid;
  logic [REG_ADDR_LENGTH-1:0] issue_rd;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
    input  alu_stall, mem_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, issue_valid, issue_rd,
    output alu_stall, mem_ready
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: ALU results win by default, buffered load returns drain
// when the ALU is idle or after STARVE_LIMIT bypassed cycles; tracks outstanding loads per register.
module reg_wb_arbiter #(
  parameter int DATA_LENGTH     = 32,
  parameter int REG_ADDR_LENGTH = 5,
  parameter int FIFO_DEPTH      = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  reg_wb_arbiter_if.slave                 bus,
  output logic [2**REG_ADDR_LENGTH-1:0]   pending,
  output logic                            RegWEn,
  output logic [REG_ADDR_LENGTH-1:0]      addrD,
  output logic [DATA_LENGTH-1:0]          dataD,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 2**REG_ADDR_LENGTH;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

  logic [REG_ADDR_LENGTH-1:0] fifoRd   [FIFO_DEPTH];
  logic [DATA_LENGTH-1:0]     fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]           wrPtr, rdPtr;
  logic [CNT_W-1:0]           count;
  logic [SW-1:0]              starve;

  logic                       fifoEmpty, forceDrain, aluWrite, push, pop;
  logic [REG_ADDR_LENGTH-1:0] headRd;
  logic [DATA_LENGTH-1:0]     headData;
  logic [NREG-1:0]            pendingNext;

  always_comb begin
    fifoEmpty     = (count == '0);
    headRd        = fifoRd[rdPtr];
    headData      = fifoData[rdPtr];
    // Accept depends only on the registered count, so a same-cycle pop never frees a slot.
    bus.mem_ready = !rst && (count != FULL_COUNT);
    forceDrain    = (starve == STARVE_MAX) && !fifoEmpty;
    aluWrite      = bus.alu_valid && (bus.alu_rd != '0);
    pop           = !rst && !fifoEmpty && (forceDrain || !aluWrite);
    push          = bus.mem_ready && bus.mem_valid && (bus.mem_rd != '0);
    bus.alu_stall = !rst && forceDrain && bus.alu_valid;

    pendingNext = pending;
    if (pop)
      pendingNext[headRd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0))
      pendingNext[bus.issue_rd] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoRd[wrPtr]   <= bus.mem_rd;
      fifoData[wrPtr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      starve  <= '0;
      pending <= '0;
      RegWEn  <= 1'b0;
      addrD   <= '0;
      dataD   <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop || fifoEmpty)
        starve <= '0;
      else if (starve != STARVE_MAX)
        starve <= starve + 1'b1;

      pending <= pendingNext;

      if (pop) begin
        RegWEn <= 1'b1;
        addrD  <= headRd;
        dataD  <= headData;
      end else if (aluWrite) begin
        RegWEn <= 1'b1;
        addrD  <= bus.alu_rd;
        dataD  <= bus.alu_data;
      end else begin
        RegWEn <= 1'b0;
      end
    end
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-computed expectations per scenario.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pending;
  logic        RegWEn;
  logic [4:0]  addrD;
  logic [31:0] dataD;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  reg_wb_arbiter_if #(.DATA_LENGTH(32), .REG_ADDR_LENGTH(5)) bus ();

  reg_wb_arbiter #(
    .DATA_LENGTH(32), .REG_ADDR_LENGTH(5), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .pending(pending), .RegWEn(RegWEn),
    .addrD(addrD), .dataD(dataD), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEAD0001;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'hDEAD0002;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    tick(); tick();
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL reset_RegWEn got %0b exp 0", RegWEn); end
    vectors++; if (addrD !== 5'd0) begin miscompares++; $display("FAIL reset_addrD got %0d exp 0", addrD); end
    vectors++; if (dataD !== 32'h0) begin miscompares++; $display("FAIL reset_dataD got %h exp 0", dataD); end
    vectors++; if (pending !== 32'h0) begin miscompares++; $display("FAIL reset_pending got %h exp 0", pending); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mem_ready got %0b exp 0", bus.mem_ready); end
    vectors++; if (bus.alu_stall !== 1'b0) begin miscompares++; $display("FAIL reset_alu_stall got %0b exp 0", bus.alu_stall); end
    idle_inputs();
    rst = 1'b0;
    #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_mem_ready got %0b exp 1", bus.mem_ready); end
    tick();
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hA5A5A5A5;
    tick();
    vectors++; if (RegWEn !== 1'b1) begin miscompares++; $display("FAIL alu_RegWEn got %0b exp 1", RegWEn); end
    vectors++; if (addrD !== 5'd5) begin miscompares++; $display("FAIL alu_addrD got %0d exp 5", addrD); end
    vectors++; if (dataD !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL alu_dataD got %h exp a5a5a5a5", dataD); end
    bus.alu_valid = 1'b0;
    tick();
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL alu_drop_RegWEn got %0b exp 0", RegWEn); end
    vectors++; if (dataD !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL alu_hold_dataD got %h exp a5a5a5a5", dataD); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00000001;
    tick();
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL alu_rd0_RegWEn got %0b exp 0", RegWEn); end
    vectors++; if (addrD !== 5'd5) begin miscompares++; $display("FAIL alu_rd0_addrD got %0d exp 5", addrD); end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_drain();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    vectors++; if (pending !== 32'h00000080) begin miscompares++; $display("FAIL drain_pending_set got %h exp 00000080", pending); end
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h12345678;
    tick();
    bus.mem_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL drain_count_push got %0d exp 1", fifo_count); end
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL drain_no_bypass got %0b exp 0", RegWEn); end
    tick();
    vectors++; if (RegWEn !== 1'b1) begin miscompares++; $display("FAIL drain_RegWEn got %0b exp 1", RegWEn); end
    vectors++; if (addrD !== 5'd7) begin miscompares++; $display("FAIL drain_addrD got %0d exp 7", addrD); end
    vectors++; if (dataD !== 32'h12345678) begin miscompares++; $display("FAIL drain_dataD got %h exp 12345678", dataD); end
    vectors++; if (pending !== 32'h0) begin miscompares++; $display("FAIL drain_pending_clear got %h exp 0", pending); end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL drain_count_pop got %0d exp 0", fifo_count); end
    tick();
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL drain_idle_RegWEn got %0b exp 0", RegWEn); end
  endtask

  task automatic test_fifo_full();
    logic [4:0]  expRd;
    logic [31:0] expData;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h00000011;
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(10 + i); bus.mem_data = 32'h100 + 32'(i);
      tick();
    end
    bus.mem_rd = 5'd14; bus.mem_data = 32'h00000104;
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_count got %0d exp 4", fifo_count); end
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL full_mem_ready got %0b exp 0", bus.mem_ready); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (bus.alu_stall !== 1'b0) begin miscompares++; $display("FAIL full_early_stall[%0d] got %0b exp 0", k, bus.alu_stall); end
      tick();
      vectors++; if (addrD !== 5'd1 || RegWEn !== 1'b1) begin miscompares++; $display("FAIL full_alu_commit[%0d] got we=%0b rd=%0d exp we=1 rd=1", k, RegWEn, addrD); end
    end
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_held_count got %0d exp 4", fifo_count); end
    vectors++; if (bus.alu_stall !== 1'b1) begin miscompares++; $display("FAIL full_force_stall got %0b exp 1", bus.alu_stall); end
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_cycle_ready got %0b exp 0", bus.mem_ready); end
    tick();
    vectors++; if (addrD !== 5'd10 || dataD !== 32'h100) begin miscompares++; $display("FAIL full_forced_pop got rd=%0d d=%h exp rd=10 d=00000100", addrD, dataD); end
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_return got %0b exp 1", bus.mem_ready); end
    vectors++; if (bus.alu_stall !== 1'b0) begin miscompares++; $display("FAIL full_stall_once got %0b exp 0", bus.alu_stall); end
    tick();
    bus.mem_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL full_fifth_push got %0d exp 4", fifo_count); end
    vectors++; if (addrD !== 5'd1 || dataD !== 32'h11) begin miscompares++; $display("FAIL full_alu_resume got rd=%0d d=%h exp rd=1 d=00000011", addrD, dataD); end
    bus.alu_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      expRd = 5'(11 + j);
      expData = 32'h101 + 32'(j);
      vectors++; if (RegWEn !== 1'b1 || addrD !== expRd || dataD !== expData) begin
        miscompares++; $display("FAIL full_drain[%0d] got we=%0b rd=%0d d=%h exp we=1 rd=%0d d=%h", j, RegWEn, addrD, dataD, expRd, expData);
      end
    end
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL full_empty_after got %0d exp 0", fifo_count); end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h00000022;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h00000033;
    tick();
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (bus.alu_stall !== 1'b0) begin miscompares++; $display("FAIL starve_stall_early[%0d] got %0b exp 0", i, bus.alu_stall); end
      tick();
      vectors++; if (RegWEn !== 1'b1 || addrD !== 5'd2 || dataD !== 32'h22) begin
        miscompares++; $display("FAIL starve_alu[%0d] got we=%0b rd=%0d d=%h exp we=1 rd=2 d=00000022", i, RegWEn, addrD, dataD);
      end
    end
    vectors++; if (bus.alu_stall !== 1'b1) begin miscompares++; $display("FAIL starve_stall got %0b exp 1", bus.alu_stall); end
    tick();
    vectors++; if (addrD !== 5'd3 || dataD !== 32'h33) begin miscompares++; $display("FAIL starve_forced got rd=%0d d=%h exp rd=3 d=00000033", addrD, dataD); end
    vectors++; if (bus.alu_stall !== 1'b0) begin miscompares++; $display("FAIL starve_stall_end got %0b exp 0", bus.alu_stall); end
    tick();
    vectors++; if (addrD !== 5'd2 || dataD !== 32'h22) begin miscompares++; $display("FAIL starve_resume got rd=%0d d=%h exp rd=2 d=00000022", addrD, dataD); end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard_race();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h00000099;
    tick();
    bus.mem_valid = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    vectors++; if (RegWEn !== 1'b1 || addrD !== 5'd9) begin miscompares++; $display("FAIL race_commit got we=%0b rd=%0d exp we=1 rd=9", RegWEn, addrD); end
    vectors++; if (pending !== 32'h00000200) begin miscompares++; $display("FAIL race_set_wins got %h exp 00000200", pending); end
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h0000009A;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    vectors++; if (pending !== 32'h0) begin miscompares++; $display("FAIL race_second_clear got %h exp 0", pending); end
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    tick();
    bus.issue_valid = 1'b0;
    vectors++; if (pending !== 32'h0) begin miscompares++; $display("FAIL issue_rd0 got %h exp 0", pending); end
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hFFFFFFFF;
    tick();
    bus.mem_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mem_rd0_discard got %0d exp 0", fifo_count); end
    tick();
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL mem_rd0_nowrite got %0b exp 0", RegWEn); end
  endtask

  task automatic test_reset_mid();
    for (int i = 8; i < 12; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(i);
      tick();
    end
    bus.issue_valid = 1'b0;
    vectors++; if (pending !== 32'h00000F00) begin miscompares++; $display("FAIL mid_pending got %h exp 00000f00", pending); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h00000044;
    for (int i = 0; i < 3; i++) begin
      bus.mem_valid = 1'b1; bus.mem_rd = 5'(8 + i); bus.mem_data = 32'h800 + 32'(i);
      tick();
    end
    bus.mem_valid = 1'b0;
    vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL mid_count got %0d exp 3", fifo_count); end
    rst = 1'b1;
    tick();
    vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_rst_count got %0d exp 0", fifo_count); end
    vectors++; if (pending !== 32'h0) begin miscompares++; $display("FAIL mid_rst_pending got %h exp 0", pending); end
    vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL mid_rst_RegWEn got %0b exp 0", RegWEn); end
    vectors++; if (bus.alu_stall !== 1'b0) begin miscompares++; $display("FAIL mid_rst_stall got %0b exp 0", bus.alu_stall); end
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (RegWEn !== 1'b0) begin miscompares++; $display("FAIL mid_stale_write[%0d] got we=%0b rd=%0d exp we=0", i, RegWEn, addrD); end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_alu_only();
    test_load_drain();
    test_fifo_full();
    test_starvation();
    test_scoreboard_race();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter that owns the register file's single write port (RegWEn/addrD/dataD). It merges the single-cycle ALU result path with the variable-latency memory load path. Load returns are buffered in a small FIFO and drained whenever the ALU path is idle, with a bounded-starvation override. It also keeps a per-register pending scoreboard of outstanding loads, which decode uses for load-use interlock.

## Interface
- DATA_LENGTH, 32, write data width
- REG_ADDR_LENGTH, 5, register address width; the register count is 2**REG_ADDR_LENGTH
- FIFO_DEPTH, 4, load-return buffer entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be bypassed by ALU writes

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  REG_ADDR_LENGTH  ALU destination register
- alu_data  in  DATA_LENGTH  ALU result
- alu_stall  out  1  ALU result not consumed this cycle; upstream holds alu_* stable
- mem_valid  in  1  load return present
- mem_rd  in  REG_ADDR_LENGTH  load destination register
- mem_data  in  DATA_LENGTH  load data
- mem_ready  out  1  FIFO can accept; the transfer occurs when mem_valid && mem_ready
- issue_valid  in  1  load issued; mark issue_rd pending
- issue_rd  in  REG_ADDR_LENGTH  register of issued load
- pending  out  2**REG_ADDR_LENGTH  bit r = load to r outstanding
- RegWEn  out  1  register file write enable (registered)
- addrD  out  REG_ADDR_LENGTH  write address (registered)
- dataD  out  DATA_LENGTH  write data (registered)
- fifo_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- **Reset values.** rst high at posedge: RegWEn=0, addrD=0, dataD=0, pending=0, fifo_count=0, starve counter=0.
  - While rst is high, mem_ready=0 and alu_stall=0, and all inputs are ignored.
- **FIFO accept.**
  - mem_ready = !rst && (fifo_count < FIFO_DEPTH), computed from registered count only.
  - A pop in the same cycle does not free a slot for that cycle.
  - An accepted return with mem_rd==0 is consumed and discarded: no push, no write.
- **Commit selection**, evaluated each cycle, result registered onto RegWEn/addrD/dataD:
  - 1. If starve counter == STARVE_LIMIT and FIFO non-empty: pop head and commit it. alu_stall = alu_valid.
  - 2. Else if alu_valid && alu_rd!=0: commit ALU result. alu_stall=0.
  - 3. Else if FIFO non-empty: pop head and commit it.
  - 4. Else RegWEn←0; addrD/dataD hold previous values.
  - alu_valid with alu_rd==0 is consumed with no write and counts as an idle ALU cycle for rule 3.
- **Starve counter.**
  - Increments when the FIFO is non-empty and no pop occurs.
  - Clears on any pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- **Scoreboard.**
  - issue_valid && issue_rd!=0 sets pending[issue_rd].
  - A FIFO-sourced commit to r clears pending[r] at the same edge RegWEn rises.
  - Set and clear to the same r in the same cycle: set wins.
  - pending[0] is constantly 0.
  - ALU commits never touch pending.
  - Decode must not issue a second load to a register whose pending bit is set.
- **Arithmetic.** FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count = pushes − pops, range 0..FIFO_DEPTH.

## Timing
- **ALU path latency.** alu_valid sampled at edge N → RegWEn/addrD/dataD valid after edge N → register file written at edge N+1.
- **Load path latency.** Push at edge N; earliest pop at edge N+1; RegWEn valid after N+1. pending clears after N+1.
- **FIFO full.** mem_ready low for the whole cycle; mem_* must be held by the source.
- **Full plus pop in the same cycle.** No accept; mem_ready rises the following cycle.
- **Empty plus push in the same cycle.** No same-cycle bypass; the entry commits at the earliest one cycle later.
- **alu_stall.** Combinational from the registered starve counter and FIFO state. Asserted for exactly one cycle per forced pop.
- **Reset mid-operation.** FIFO contents are discarded and pending is cleared. RegWEn=0 the cycle after the reset edge.

## Test plan
- **ALU-only stream.** alu_valid=1, rd=5, data=0xA5A5A5A5 at edge N → RegWEn=1, addrD=5, dataD=0xA5A5A5A5 after N, then RegWEn=0 when alu_valid drops. Also: rd=0 → RegWEn stays 0.
- **Load drain.** issue rd=7; push mem rd=7, data=0x12345678 with ALU idle → pending[7]=1, then RegWEn=1/addrD=7/dataD=0x12345678 one cycle after push; pending[7]=0 the same cycle.
- **FIFO full.** Hold alu_valid=1 (rd=1) and push 4 loads → fifo_count=4, mem_ready=0, and a 5th load is held. After the starve override pops one, mem_ready returns to 1 the next cycle.
- **Starvation bound.** FIFO holds 1 entry and alu_valid is held continuously → exactly STARVE_LIMIT=8 ALU commits, then one cycle with alu_stall=1 and the FIFO entry committed, then ALU resumes with the held data.
- **Scoreboard race.** Commit of load to rd=9 coincides with issue_valid rd=9 → pending[9] remains 1. Separately: issue rd=0 → pending stays all-zero.
- **Reset mid-operation.** Assert rst with 3 FIFO entries and pending=0x00000F00 → fifo_count=0, pending=0, RegWEn=0, and no stale write after rst deasserts.
